// File: rtl/uart_sched.sv
// uart_sched: owns the UART register interface. Shares the TX path between
// two byte-stream requesters (0 = CPU console, 1 = debug monitor) with
// round-robin arbitration and packet locking, and drains received bytes to a
// single RX stream. Issues single-cycle read/write strobes and checks the
// registered ack. All outputs are registered.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   tx_valid/data/last[0,1]   requester byte streams, held until tx_ready
//   tx_ready0, tx_ready1      byte consumed (or dropped), 1-cycle pulse
//   rx_data, rx_valid         received byte, 1-cycle valid pulse
//   tx_err                    byte dropped after RETRY_MAX un-acked strobes
//   grant                     one-hot current TX owner, 00 = none
//   u_addr, u_data_write      UART address / write data (byte in [15:8])
//   u_uds, u_lds, u_rw        UART strobes (u_lds tied 0), 1 = read
//   u_ack, u_data_read        UART registered ack / read data (byte in [15:8])
//   u_tx_active, u_rx_avail   UART transmitter busy / rx byte pending
module uart_sched #(
  parameter logic [7:0] UART_ADDR = 8'h00,
  parameter int         RETRY_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_valid0,
  input  logic [7:0]  tx_data0,
  input  logic        tx_last0,
  output logic        tx_ready0,
  input  logic        tx_valid1,
  input  logic [7:0]  tx_data1,
  input  logic        tx_last1,
  output logic        tx_ready1,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        tx_err,
  output logic [1:0]  grant,
  output logic [7:0]  u_addr,
  output logic [15:0] u_data_write,
  output logic        u_uds,
  output logic        u_lds,
  output logic        u_rw,
  input  logic        u_ack,
  input  logic [15:0] u_data_read,
  input  logic        u_tx_active,
  input  logic        u_rx_avail
);

  typedef enum logic [2:0] {IDLE, RD_STB, RD_ACK, WR_STB, WR_ACK} state_t;

  // Retry counter only needs to hold 0..RETRY_MAX-1; the last failed strobe
  // drops the byte instead of incrementing.
  localparam int            CW         = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX);
  localparam logic [CW-1:0] RETRY_LAST = CW'(RETRY_MAX - 1);

  state_t        state, next_state;
  logic [CW-1:0] retry_cnt;
  logic          rr_ptr;
  logic          cand0, cand1;
  logic [1:0]    sel;
  logic [7:0]    sel_data;
  logic          owner_last;
  logic          wr_done;

  // Candidate selection and next-state logic.
  // A requester whose tx_ready pulse is currently out still shows its old
  // byte this cycle, so it is masked to avoid resending a consumed byte.
  always_comb begin
    cand0      = tx_valid0 && !tx_ready0;
    cand1      = tx_valid1 && !tx_ready1;
    sel        = 2'b00;
    next_state = state;

    // A locked owner is the only candidate, even if it has paused mid-packet.
    case (grant)
      2'b01: sel = {1'b0, cand0};
      2'b10: sel = {cand1, 1'b0};
      2'b00: begin
        if (!rr_ptr) sel = cand0 ? 2'b01 : (cand1 ? 2'b10 : 2'b00);
        else         sel = cand1 ? 2'b10 : (cand0 ? 2'b01 : 2'b00);
      end
      default: sel = 2'b00;
    endcase

    sel_data   = sel[1] ? tx_data1 : tx_data0;
    owner_last = grant[1] ? tx_last1 : tx_last0;
    wr_done    = u_ack || (retry_cnt == RETRY_LAST);

    // RX is checked first so a pending received byte is never overrun.
    case (state)
      IDLE: begin
        if (u_rx_avail)                        next_state = RD_STB;
        else if (!u_tx_active && sel != 2'b00) next_state = WR_STB;
      end
      RD_STB:  next_state = RD_ACK;
      RD_ACK:  next_state = IDLE;
      WR_STB:  next_state = WR_ACK;
      WR_ACK:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Registered outputs, arbitration state and retry bookkeeping.
  // Strobes are derived from next_state so u_uds is high exactly during the
  // RD_STB/WR_STB cycle; both are only entered from IDLE, so never back-to-back.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant        <= 2'b00;
      rr_ptr       <= 1'b0;
      retry_cnt    <= '0;
      tx_ready0    <= 1'b0;
      tx_ready1    <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= 8'h00;
      tx_err       <= 1'b0;
      u_addr       <= UART_ADDR;
      u_data_write <= 16'h0000;
      u_uds        <= 1'b0;
      u_lds        <= 1'b0;
      u_rw         <= 1'b1;
    end else begin
      tx_ready0 <= 1'b0;
      tx_ready1 <= 1'b0;
      rx_valid  <= 1'b0;
      tx_err    <= 1'b0;
      u_addr    <= UART_ADDR;
      u_lds     <= 1'b0;
      u_uds     <= (next_state == RD_STB) || (next_state == WR_STB);
      u_rw      <= (next_state != WR_STB);

      if (state == IDLE && next_state == WR_STB) begin
        grant        <= sel;
        u_data_write <= {sel_data, 8'h00};
      end

      if (state == RD_ACK && u_ack) begin
        rx_data  <= u_data_read[15:8];
        rx_valid <= 1'b1;
      end

      // A drop completes the byte exactly like an ack, plus tx_err.
      if (state == WR_ACK) begin
        if (wr_done) begin
          tx_ready0 <= grant[0];
          tx_ready1 <= grant[1];
          tx_err    <= !u_ack;
          retry_cnt <= '0;
          if (owner_last) begin
            grant  <= 2'b00;
            rr_ptr <= grant[0];
          end
        end else begin
          retry_cnt <= retry_cnt + 1'b1;
        end
      end
    end
  end

endmodule
